// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: accepts an MDU op, holds the
// multi-cycle busy window, owns HI/LO and raises the D-stage stall.
//
// state | meaning
// IDLE  | no operation running; new ops and mthi/mtlo accepted
// RUN   | result pending in phi/plo, cnt counting down to commit
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_E,
   input  logic [3:0]  mdu_op_E,
   input  logic [31:0] rs_E,
   input  logic [31:0] rt_E,
   input  logic        req,
   input  logic        md_D,
   output logic        busy,
   output logic        stall_D,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_out_E
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] phi_q, phi_d;
   logic [31:0] plo_q, plo_d;

   logic        go;
   logic        long_op;
   logic        div_zero;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic signed [32:0] dvd_s;
   logic signed [32:0] dvs_s;
   logic [31:0] quo_s, rem_s;
   logic [31:0] quo_u, rem_u;

   assign busy     = (state_q == RUN);
   assign go       = start_E & ~req & ~busy;
   assign long_op  = (mdu_op_E >= OP_MULT) && (mdu_op_E <= OP_DIVU);
   assign div_zero = (rt_E == 32'd0);
   assign stall_D  = md_D & (busy | (start_E & long_op));
   assign hi       = hi_q;
   assign lo       = lo_q;

   // Operand arithmetic; signed divide is done one bit wider so that
   // 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
   always_comb begin
      prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
      prod_u = {32'd0, rs_E} * {32'd0, rt_E};
      dvd_s  = $signed({rs_E[31], rs_E});
      dvs_s  = $signed({rt_E[31], rt_E});
      quo_s  = 32'(dvd_s / dvs_s);
      rem_s  = 32'(dvd_s % dvs_s);
      quo_u  = rs_E / rt_E;
      rem_u  = rs_E % rt_E;
   end

   // Read port for mfhi/mflo.
   always_comb begin
      mdu_out_E = 32'd0;
      if (mdu_op_E == OP_MFHI)
         mdu_out_E = hi_q;
      else if (mdu_op_E == OP_MFLO)
         mdu_out_E = lo_q;
   end

   // Next-state logic: issue, countdown and HI/LO commit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      case (state_q)
         IDLE: begin
            if (go) begin
               case (mdu_op_E)
                  OP_MULT: begin
                     {phi_d, plo_d} = prod_s;
                     cnt_d   = MULT_LOAD;
                     state_d = RUN;
                  end
                  OP_MULTU: begin
                     {phi_d, plo_d} = prod_u;
                     cnt_d   = MULT_LOAD;
                     state_d = RUN;
                  end
                  OP_DIV: begin
                     phi_d   = div_zero ? hi_q : rem_s;
                     plo_d   = div_zero ? lo_q : quo_s;
                     cnt_d   = DIV_LOAD;
                     state_d = RUN;
                  end
                  OP_DIVU: begin
                     phi_d   = div_zero ? hi_q : rem_u;
                     plo_d   = div_zero ? lo_q : quo_u;
                     cnt_d   = DIV_LOAD;
                     state_d = RUN;
                  end
                  OP_MTHI: hi_d = rs_E;
                  OP_MTLO: lo_d = rs_E;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               hi_d    = phi_q;
               lo_d    = plo_q;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any pending result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         phi_q   <= 32'd0;
         plo_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected completions and
// reads into queues, a negedge monitor pops and compares.
module tb_mdu_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } cexp_t;

   logic        clk;
   logic        reset;
   logic        start_E;
   logic [3:0]  mdu_op_E;
   logic [31:0] rs_E;
   logic [31:0] rt_E;
   logic        req;
   logic        md_D;
   logic        busy;
   logic        stall_D;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mdu_out_E;

   int          n_checks = 0;
   int          n_fail   = 0;
   cexp_t       cq[$];
   logic [31:0] rq[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [3:0]  junk_ops [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};

   mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk       (clk),
      .reset     (reset),
      .start_E   (start_E),
      .mdu_op_E  (mdu_op_E),
      .rs_E      (rs_E),
      .rt_E      (rt_E),
      .req       (req),
      .md_D      (md_D),
      .busy      (busy),
      .stall_D   (stall_D),
      .hi        (hi),
      .lo        (lo),
      .mdu_out_E (mdu_out_E)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running, need finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference results straight from the arithmetic definitions.
   function automatic logic [63:0] model_long(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] h,
                                              input logic [31:0] l);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, p;
      logic [31:0]     uq, ur;
      sa = $signed(a);
      sb = $signed(b);
      ua = 64'(a);
      ub = 64'(b);
      case (op)
         4'd1: begin
            q = sa * sb;
            return q;
         end
         4'd2: begin
            p = ua * ub;
            return p;
         end
         4'd3: begin
            if (b == 32'd0) return {h, l};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {h, l};
            uq = a / b;
            ur = a % b;
            return {ur, uq};
         end
      endcase
   endfunction

   function automatic logic pick_md(input int sel);
      if (sel == 2) return 1'($urandom_range(0, 1));
      return (sel == 1);
   endfunction

   // One clock cycle of stimulus; entered and left 1 time unit after posedge.
   task automatic cyc(input logic s, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic r, input logic md, input logic exp_busy);
      logic exp_stall;
      start_E  = s;
      mdu_op_E = op;
      rs_E     = a;
      rt_E     = b;
      req      = r;
      md_D     = md;
      exp_stall = md & (exp_busy | (s & (op >= 4'd1) & (op <= 4'd4)));
      #2;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("stall_D", 32'(stall_D), 32'(exp_stall));
      @(posedge clk);
      #1;
   endtask

   // Issue one op from an idle DUT; for mult/div also run its busy window
   // with ignored junk starts.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic r, input int md_sel);
      logic        long_op;
      logic [63:0] res;
      cexp_t       e;
      int          n;
      long_op = (op >= 4'd1) && (op <= 4'd4) && !r;
      n = (op <= 4'd2) ? MULT_N : DIV_N;
      if (op == 4'd5) rq.push_back(m_hi);
      else if (op == 4'd6) rq.push_back(m_lo);
      if (!r) begin
         if (long_op) begin
            res  = model_long(op, a, b, m_hi, m_lo);
            e.hi = res[63:32];
            e.lo = res[31:0];
            e.n  = n;
            cq.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
         end else if (op == 4'd7) begin
            m_hi = a;
         end else if (op == 4'd8) begin
            m_lo = a;
         end
      end
      cyc(1'b1, op, a, b, r, pick_md(md_sel), 1'b0);
      if (long_op) begin
         for (int i = 0; i < n; i++)
            cyc(1'($urandom_range(0, 1)), junk_ops[$urandom_range(0, 6)], $urandom,
                $urandom, 1'($urandom_range(0, 1)), pick_md(md_sel), 1'b1);
      end
   endtask

   // Monitor: completions on busy falling, reads on mfhi/mflo presentation.
   initial begin
      logic busy_prev;
      int   busy_cnt;
      cexp_t e;
      logic [31:0] rexp;
      busy_prev = 1'b0;
      busy_cnt  = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            busy_prev = 1'b0;
            busy_cnt  = 0;
         end else begin
            if (busy) busy_cnt++;
            if (busy_prev && !busy) begin
               if (cq.size() == 0) begin
                  chk("unexpected_completion", 32'd1, 32'd0);
               end else begin
                  e = cq.pop_front();
                  chk("done_hi", hi, e.hi);
                  chk("done_lo", lo, e.lo);
                  chk("busy_len", 32'(busy_cnt), 32'(e.n));
               end
               busy_cnt = 0;
            end
            busy_prev = busy;
            if (start_E && (mdu_op_E == 4'd5 || mdu_op_E == 4'd6)) begin
               if (rq.size() == 0) begin
                  chk("unexpected_read", 32'd1, 32'd0);
               end else begin
                  rexp = rq.pop_front();
                  chk("mdu_out_E", mdu_out_E, rexp);
               end
            end
         end
      end
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      logic        r;
      reset = 1'b0;
      start_E = 1'b0; mdu_op_E = 4'd0; rs_E = 32'd0; rt_E = 32'd0; req = 1'b0; md_D = 1'b1;
      #3;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_stall", 32'(stall_D), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Directed arithmetic cases.
      do_op(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 1);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFF1);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      do_op(4'd2, 32'hFFFFFFFD, 32'd5, 1'b0, 0);
      chk("multu_hi", hi, 32'h00000004);
      chk("multu_lo", lo, 32'hFFFFFFF1);
      do_op(4'd4, 32'd100, 32'd7, 1'b0, 2);
      chk("divu_hi", hi, 32'd2);
      chk("divu_lo", lo, 32'd14);
      do_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 2);
      chk("div_hi", hi, 32'hFFFFFFFF);
      chk("div_lo", lo, 32'hFFFFFFFD);
      do_op(4'd5, 32'd0, 32'd0, 1'b0, 0);

      // Divide by zero keeps HI/LO.
      do_op(4'd7, 32'h11, 32'd0, 1'b0, 0);
      do_op(4'd8, 32'h22, 32'd0, 1'b0, 0);
      do_op(4'd5, 32'd0, 32'd0, 1'b0, 0);
      do_op(4'd6, 32'd0, 32'd0, 1'b0, 0);
      do_op(4'd3, 32'h1234, 32'd0, 1'b0, 1);
      chk("div0_hi", hi, 32'h11);
      chk("div0_lo", lo, 32'h22);
      chk("div0_busy", 32'(busy), 32'd0);

      // req blocks a new start and an mt write.
      do_op(4'd1, 32'd9, 32'd9, 1'b1, 0);
      chk("req_busy", 32'(busy), 32'd0);
      chk("req_hi", hi, 32'h11);
      chk("req_lo", lo, 32'h22);
      do_op(4'd7, 32'hDEAD, 32'd0, 1'b1, 0);
      chk("req_mthi", hi, 32'h11);

      // Signed divide overflow corner.
      do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 2);

      // Reset in the third cycle of a div.
      cyc(1'b1, 4'd3, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      #1;
      reset = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      do_op(4'd1, 32'd6, 32'd7, 1'b0, 0);
      chk("postrst_lo", lo, 32'd42);
      chk("postrst_hi", hi, 32'd0);

      // Random traffic.
      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 15) == 0) a = 32'h80000000;
         r = ($urandom_range(0, 7) == 0);
         do_op(op, a, b, r, 2);
      end
      do_op(4'd5, 32'd0, 32'd0, 1'b0, 0);
      do_op(4'd6, 32'd0, 32'd0, 1'b0, 0);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

      chk("final_hi", hi, m_hi);
      chk("final_lo", lo, m_lo);
      chk("cq_drained", 32'(cq.size()), 32'd0);
      chk("rq_drained", 32'(rq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
